// File: rtl/alu_pkg.sv
// Shared ALU op codes and operand-select encodings used by decode, ID/EX and the ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_XOR  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_AND  = 4'h5,
    ALU_SLL  = 4'h6,
    ALU_SRL  = 4'h7,
    ALU_SRA  = 4'h8,
    ALU_SLT  = 4'h9,
    ALU_SLTU = 4'hA
  } alu_op_e;

  localparam logic A_RS1 = 1'b0;
  localparam logic A_PC  = 1'b1;
  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-source-register forwarding select: EX/MEM beats MEM/WB beats the registered value.
module fwd_mux #(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic [REG_ADDR-1:0]  addr,
  input  logic [WORD_SIZE-1:0] reg_data,
  input  logic                 exm_reg_write,
  input  logic [REG_ADDR-1:0]  exm_rd_addr,
  input  logic [WORD_SIZE-1:0] exm_result,
  input  logic                 mwb_reg_write,
  input  logic [REG_ADDR-1:0]  mwb_rd_addr,
  input  logic [WORD_SIZE-1:0] mwb_result,
  output logic [WORD_SIZE-1:0] data
);

  always_comb begin
    data = reg_data;
    // x0 is hardwired zero, so a write to it must never shadow the register value
    if (addr != '0) begin
      if (exm_reg_write && (exm_rd_addr == addr)) begin
        data = exm_result;
      end else if (mwb_reg_write && (mwb_rd_addr == addr)) begin
        data = mwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, operand select and load-use bubble insertion.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [WORD_SIZE-1:0] id_pc,
  input  logic [WORD_SIZE-1:0] id_rs1_data,
  input  logic [WORD_SIZE-1:0] id_rs2_data,
  input  logic [WORD_SIZE-1:0] id_imm,
  input  logic [REG_ADDR-1:0]  id_rs1_addr,
  input  logic [REG_ADDR-1:0]  id_rs2_addr,
  input  logic [REG_ADDR-1:0]  id_rd_addr,
  input  logic [3:0]           id_alu_sel,
  input  logic                 id_a_sel,
  input  logic                 id_b_sel,
  input  logic                 id_mem_read,
  input  logic                 id_reg_write,
  input  logic                 flush,
  input  logic                 exm_reg_write,
  input  logic [REG_ADDR-1:0]  exm_rd_addr,
  input  logic [WORD_SIZE-1:0] exm_result,
  input  logic                 mwb_reg_write,
  input  logic [REG_ADDR-1:0]  mwb_rd_addr,
  input  logic [WORD_SIZE-1:0] mwb_result,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [WORD_SIZE-1:0] arg_a,
  output logic [WORD_SIZE-1:0] arg_b,
  output logic [3:0]           alu_sel,
  output logic [WORD_SIZE-1:0] ex_store_data,
  output logic [REG_ADDR-1:0]  ex_rd_addr,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read
);

  logic                 valid_q;
  logic [WORD_SIZE-1:0] pc_q;
  logic [WORD_SIZE-1:0] rs1_data_q;
  logic [WORD_SIZE-1:0] rs2_data_q;
  logic [WORD_SIZE-1:0] imm_q;
  logic [REG_ADDR-1:0]  rs1_addr_q;
  logic [REG_ADDR-1:0]  rs2_addr_q;
  logic [REG_ADDR-1:0]  rd_addr_q;
  logic [3:0]           alu_sel_q;
  logic                 a_sel_q;
  logic                 b_sel_q;
  logic                 mem_read_q;
  logic                 reg_write_q;

  logic                 adv;
  logic                 haz;
  logic [WORD_SIZE-1:0] rs1_fwd;
  logic [WORD_SIZE-1:0] rs2_fwd;

  assign adv = ex_ready | ~valid_q;

  // Both source addresses are compared unconditionally; an occasional spurious stall is cheaper than decoding usage
  assign haz = valid_q & mem_read_q & (rd_addr_q != '0) & id_valid &
               ((id_rs1_addr == rd_addr_q) | (id_rs2_addr == rd_addr_q));

  assign id_ready = flush | (adv & ~haz);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_sel_q   <= '0;
      a_sel_q     <= 1'b0;
      b_sel_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (flush || (adv && haz)) begin
      valid_q     <= 1'b0;
      rd_addr_q   <= '0;
      alu_sel_q   <= '0;
      mem_read_q  <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (adv) begin
      valid_q    <= id_valid;
      pc_q       <= id_pc;
      rs1_data_q <= id_rs1_data;
      rs2_data_q <= id_rs2_data;
      imm_q      <= id_imm;
      rs1_addr_q <= id_rs1_addr;
      rs2_addr_q <= id_rs2_addr;
      a_sel_q    <= id_a_sel;
      b_sel_q    <= id_b_sel;
      // An empty slot must not look like a writer or a load to forwarding/hazard logic
      if (id_valid) begin
        rd_addr_q   <= id_rd_addr;
        alu_sel_q   <= id_alu_sel;
        mem_read_q  <= id_mem_read;
        reg_write_q <= id_reg_write;
      end else begin
        rd_addr_q   <= '0;
        alu_sel_q   <= '0;
        mem_read_q  <= 1'b0;
        reg_write_q <= 1'b0;
      end
    end
  end

  fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_ADDR(REG_ADDR)) u_fwd_rs1 (
    .addr          (rs1_addr_q),
    .reg_data      (rs1_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .mwb_result    (mwb_result),
    .data          (rs1_fwd)
  );

  fwd_mux #(.WORD_SIZE(WORD_SIZE), .REG_ADDR(REG_ADDR)) u_fwd_rs2 (
    .addr          (rs2_addr_q),
    .reg_data      (rs2_data_q),
    .exm_reg_write (exm_reg_write),
    .exm_rd_addr   (exm_rd_addr),
    .exm_result    (exm_result),
    .mwb_reg_write (mwb_reg_write),
    .mwb_rd_addr   (mwb_rd_addr),
    .mwb_result    (mwb_result),
    .data          (rs2_fwd)
  );

  assign arg_a         = (a_sel_q == A_PC)  ? pc_q  : rs1_fwd;
  assign arg_b         = (b_sel_q == B_IMM) ? imm_q : rs2_fwd;
  assign ex_store_data = rs2_fwd;
  assign ex_valid      = valid_q;
  assign alu_sel       = alu_sel_q;
  assign ex_rd_addr    = rd_addr_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding, load-use bubble, stall/flush, operand select.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [3:0]  id_alu_sel;
  logic        id_a_sel, id_b_sel, id_mem_read, id_reg_write;
  logic        flush;
  logic        exm_reg_write;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        mwb_reg_write;
  logic [4:0]  mwb_rd_addr;
  logic [31:0] mwb_result;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] arg_a, arg_b, ex_store_data;
  logic [3:0]  alu_sel;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write, ex_mem_read;

  int checks;
  int failures;

  id_ex_stage #(.WORD_SIZE(32), .REG_ADDR(5)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
    .id_alu_sel(id_alu_sel), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .arg_a(arg_a), .arg_b(arg_b), .alu_sel(alu_sel), .ex_store_data(ex_store_data),
    .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0; id_alu_sel = '0;
    id_a_sel = 0; id_b_sel = 0; id_mem_read = 0; id_reg_write = 0;
    flush = 0; ex_ready = 1;
    exm_reg_write = 0; exm_rd_addr = '0; exm_result = '0;
    mwb_reg_write = 0; mwb_rd_addr = '0; mwb_result = '0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1a, input logic [31:0] rs1d,
                       input logic [4:0] rs2a, input logic [31:0] rs2d, input logic [31:0] imm,
                       input logic [4:0] rd, input logic [3:0] op, input logic asel, input logic bsel,
                       input logic mrd, input logic rwr);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1a; id_rs1_data = rs1d;
    id_rs2_addr = rs2a; id_rs2_data = rs2d; id_imm = imm; id_rd_addr = rd;
    id_alu_sel = op; id_a_sel = asel; id_b_sel = bsel; id_mem_read = mrd; id_reg_write = rwr;
  endtask

  task automatic test_reset();
    rst = 1;
    set_idle();
    #2;
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
    checks++; if (alu_sel !== 4'd0) begin failures++; $display("FAIL reset_alu_sel got=%0h exp=0", alu_sel); end
    checks++; if (arg_a !== 32'd0 || arg_b !== 32'd0 || ex_store_data !== 32'd0) begin failures++; $display("FAIL reset_args got=%h/%h/%h exp=0", arg_a, arg_b, ex_store_data); end
    checks++; if (ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd_addr !== 5'd0) begin failures++; $display("FAIL reset_ctrl got=%b%b%0d exp=000", ex_reg_write, ex_mem_read, ex_rd_addr); end
    #10 rst = 0;
    #1;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
  endtask

  task automatic test_plain_add();
    offer(32'h40, 5'd5, 32'd10, 5'd6, 32'd20, 32'd0, 5'd7, 4'h1, 0, 0, 0, 1);
    #1;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL add_id_ready got=%0b exp=1", id_ready); end
    step();
    id_valid = 0;
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%0b exp=1", ex_valid); end
    checks++; if (arg_a !== 32'd10 || arg_b !== 32'd20) begin failures++; $display("FAIL add_args got=%0d/%0d exp=10/20", arg_a, arg_b); end
    checks++; if (alu_sel !== 4'h1 || ex_rd_addr !== 5'd7 || ex_reg_write !== 1'b1) begin failures++; $display("FAIL add_ctrl got=%0h/%0d/%0b exp=1/7/1", alu_sel, ex_rd_addr, ex_reg_write); end
    checks++; if (ex_store_data !== 32'd20) begin failures++; $display("FAIL add_store got=%0d exp=20", ex_store_data); end
    step();
    checks++; if (ex_valid !== 1'b0 || alu_sel !== 4'd0 || ex_reg_write !== 1'b0 || ex_rd_addr !== 5'd0) begin failures++; $display("FAIL add_drain got=%0b/%0h/%0b/%0d exp=0/0/0/0", ex_valid, alu_sel, ex_reg_write, ex_rd_addr); end
  endtask

  task automatic test_fwd_priority();
    offer(32'h0, 5'd3, 32'd100, 5'd0, 32'd55, 32'd0, 5'd9, 4'h1, 0, 0, 0, 1);
    step();
    id_valid = 0;
    exm_reg_write = 1; exm_rd_addr = 5'd3; exm_result = 32'd7;
    mwb_reg_write = 1; mwb_rd_addr = 5'd3; mwb_result = 32'd9;
    #1;
    checks++; if (arg_a !== 32'd7) begin failures++; $display("FAIL fwd_exm_wins got=%0d exp=7", arg_a); end
    checks++; if (arg_b !== 32'd55) begin failures++; $display("FAIL fwd_rs2_x0 got=%0d exp=55", arg_b); end
    exm_reg_write = 0;
    #1;
    checks++; if (arg_a !== 32'd9) begin failures++; $display("FAIL fwd_mwb got=%0d exp=9", arg_a); end
    mwb_reg_write = 0;
    #1;
    checks++; if (arg_a !== 32'd100) begin failures++; $display("FAIL fwd_none got=%0d exp=100", arg_a); end
    offer(32'h0, 5'd0, 32'd11, 5'd3, 32'd44, 32'd0, 5'd2, 4'h3, 0, 0, 0, 1);
    step();
    id_valid = 0;
    exm_reg_write = 1; exm_rd_addr = 5'd0; exm_result = 32'd7;
    mwb_reg_write = 1; mwb_rd_addr = 5'd0; mwb_result = 32'd9;
    #1;
    checks++; if (arg_a !== 32'd11 || arg_b !== 32'd44) begin failures++; $display("FAIL fwd_x0 got=%0d/%0d exp=11/44", arg_a, arg_b); end
    exm_reg_write = 0; mwb_reg_write = 0;
    step();
  endtask

  task automatic test_load_use();
    int bubbles;
    offer(32'h80, 5'd1, 32'h1000, 5'd0, 32'd0, 32'd4, 5'd4, 4'h1, 0, 1, 1, 1);
    step();
    checks++; if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_rd_addr !== 5'd4) begin failures++; $display("FAIL lu_load got=%0b/%0b/%0d exp=1/1/4", ex_valid, ex_mem_read, ex_rd_addr); end
    checks++; if (arg_b !== 32'd4) begin failures++; $display("FAIL lu_load_imm got=%0d exp=4", arg_b); end
    offer(32'h84, 5'd2, 32'd5, 5'd4, 32'hDEAD, 32'd0, 5'd8, 4'h1, 0, 0, 0, 1);
    #1;
    checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL lu_stall got=%0b exp=0", id_ready); end
    bubbles = 0;
    for (int i = 0; i < 4 && ex_valid !== 1'b1 || i == 0; i++) begin
      step();
      if (ex_valid !== 1'b1) begin
        bubbles++;
        checks++; if (alu_sel !== 4'd0 || ex_mem_read !== 1'b0) begin failures++; $display("FAIL lu_bubble_ctrl got=%0h/%0b exp=0/0", alu_sel, ex_mem_read); end
        mwb_reg_write = 1; mwb_rd_addr = 5'd4; mwb_result = 32'h1234;
      end
    end
    id_valid = 0;
    checks++; if (bubbles != 1) begin failures++; $display("FAIL lu_bubbles got=%0d exp=1", bubbles); end
    checks++; if (ex_valid !== 1'b1 || alu_sel !== 4'h1 || ex_rd_addr !== 5'd8) begin failures++; $display("FAIL lu_dep got=%0b/%0h/%0d exp=1/1/8", ex_valid, alu_sel, ex_rd_addr); end
    checks++; if (arg_a !== 32'd5 || arg_b !== 32'h1234) begin failures++; $display("FAIL lu_dep_args got=%h/%h exp=5/1234", arg_a, arg_b); end
    mwb_reg_write = 0;
    step();
  endtask

  task automatic test_stall_flush();
    offer(32'h0, 5'd9, 32'h11, 5'd10, 32'h22, 32'd0, 5'd3, 4'h2, 0, 0, 0, 1);
    step();
    ex_ready = 0;
    offer(32'h4, 5'd1, 32'h33, 5'd2, 32'h44, 32'd0, 5'd6, 4'h3, 0, 0, 0, 1);
    #1;
    checks++; if (id_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0b exp=0", id_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ex_valid !== 1'b1 || arg_a !== 32'h11 || arg_b !== 32'h22 || alu_sel !== 4'h2 || ex_rd_addr !== 5'd3 || id_ready !== 1'b0) begin
        failures++; $display("FAIL stall_hold cyc=%0d got=%0b/%h/%h/%0h/%0d/%0b exp=1/11/22/2/3/0", i, ex_valid, arg_a, arg_b, alu_sel, ex_rd_addr, id_ready);
      end
    end
    flush = 1;
    #1;
    checks++; if (id_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", id_ready); end
    step();
    flush = 0; id_valid = 0; ex_ready = 1;
    checks++; if (ex_valid !== 1'b0 || alu_sel !== 4'd0 || ex_reg_write !== 1'b0) begin failures++; $display("FAIL flush_clear got=%0b/%0h/%0b exp=0/0/0", ex_valid, alu_sel, ex_reg_write); end
    step();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0b exp=0", ex_valid); end
  endtask

  task automatic test_operand_select();
    offer(32'h100, 5'd5, 32'd1, 5'd6, 32'h77, 32'hFFFFFFFC, 5'd1, 4'h1, 1, 1, 0, 1);
    step();
    id_valid = 0;
    checks++; if (arg_a !== 32'h100 || arg_b !== 32'hFFFFFFFC) begin failures++; $display("FAIL sel_args got=%h/%h exp=100/fffffffc", arg_a, arg_b); end
    checks++; if (ex_store_data !== 32'h77) begin failures++; $display("FAIL sel_store got=%h exp=77", ex_store_data); end
    exm_reg_write = 1; exm_rd_addr = 5'd6; exm_result = 32'hABC;
    #1;
    checks++; if (ex_store_data !== 32'hABC || arg_b !== 32'hFFFFFFFC) begin failures++; $display("FAIL sel_store_fwd got=%h/%h exp=abc/fffffffc", ex_store_data, arg_b); end
    exm_reg_write = 0;
    step();
  endtask

  task automatic test_back_to_back();
    offer(32'h200, 5'd11, 32'hA1, 5'd12, 32'hB1, 32'd0, 5'd13, 4'h4, 0, 0, 0, 1);
    step();
    checks++; if (ex_valid !== 1'b1 || arg_a !== 32'hA1 || alu_sel !== 4'h4) begin failures++; $display("FAIL b2b_first got=%0b/%h/%0h exp=1/a1/4", ex_valid, arg_a, alu_sel); end
    offer(32'h204, 5'd14, 32'hA2, 5'd15, 32'hB2, 32'd0, 5'd16, 4'h5, 0, 0, 0, 1);
    step();
    id_valid = 0;
    checks++; if (ex_valid !== 1'b1 || arg_a !== 32'hA2 || arg_b !== 32'hB2 || alu_sel !== 4'h5 || ex_rd_addr !== 5'd16) begin failures++; $display("FAIL b2b_second got=%0b/%h/%h/%0h/%0d exp=1/a2/b2/5/16", ex_valid, arg_a, arg_b, alu_sel, ex_rd_addr); end
  endtask

  task automatic test_reset_midstream();
    offer(32'h300, 5'd7, 32'h5A5A, 5'd8, 32'h6B6B, 32'd0, 5'd9, 4'h9, 0, 0, 0, 1);
    step();
    id_valid = 0;
    checks++; if (ex_valid !== 1'b1 || arg_a !== 32'h5A5A) begin failures++; $display("FAIL mid_pre got=%0b/%h exp=1/5a5a", ex_valid, arg_a); end
    #2 rst = 1;
    #1;
    checks++; if (ex_valid !== 1'b0 || alu_sel !== 4'd0 || arg_a !== 32'd0 || arg_b !== 32'd0) begin failures++; $display("FAIL mid_reset got=%0b/%0h/%h/%h exp=0/0/0/0", ex_valid, alu_sel, arg_a, arg_b); end
    #1 rst = 0;
    step();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_plain_add();
    test_fwd_priority();
    test_load_use();
    test_stall_flush();
    test_operand_select();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
